pipelined_adder_tree: RTL and testbench

Parametrised, fully pipelined signed reduction tree with valid/ready handshaking and a group accumulator. Each accepted beat carries `ELEMENTS` signed words. A registered binary tree reduces them to one sum, and the final stage accumulates sums across beats until the beat flagged `in_last`. The block sits between a vector producer (e.g. a multiply stage of the dot-product engine) and the downstream result consumer. It replaces purely combinational reduction where timing closure and backpressure are needed.

---
 rtl/pipelined_adder_tree.sv | 120 ++++++++++++
 tb/tb_pipelined_adder_tree.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder_tree.sv
// Pipelined signed reduction tree with a group accumulator and valid/ready flow control.
// Define ADDER_TREE_SATURATE_EN to clamp the accumulator instead of letting it wrap.
module pipelined_adder_tree #(
    parameter int ELEMENTS  = 16,
    parameter int IN_WIDTH  = 8,
    parameter int OUT_WIDTH = 32
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic [ELEMENTS*IN_WIDTH-1:0] in_data,
    input  logic                         in_valid,
    input  logic                         in_last,
    output logic                         in_ready,
    output logic [OUT_WIDTH-1:0]         out_data,
    output logic                         out_valid,
    input  logic                         out_ready
);
    localparam int L  = $clog2(ELEMENTS);
    localparam int TW = IN_WIDTH + L;

    logic                        out_valid_q;
    logic signed [OUT_WIDTH-1:0] out_data_q;
    logic signed [OUT_WIDTH-1:0] acc_q;
    logic                        first_q;
    logic                        adv;

    // Valid/ready: a beat moves when in_valid && in_ready; a result leaves when
    // out_valid && out_ready. The whole pipeline advances or stalls as one.
    assign adv       = !out_valid_q || out_ready;
    assign in_ready  = !rst_in && adv;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    for (genvar k = 0; k <= L; k++) begin : g_lvl
        localparam int N = ELEMENTS >> k;
        localparam int W = IN_WIDTH + k;
        logic [N*W-1:0] data;
        logic           vld;
        logic           lst;

        if (k == 0) begin : g_in
            assign data = in_data;
            assign vld  = in_valid && in_ready;
            assign lst  = in_last;
        end else begin : g_reg
            logic [N*W-1:0] sum_d;
            logic [N*W-1:0] data_q;
            logic           vld_q;
            logic           lst_q;

            // Each pair grows by one bit so no level ever loses precision.
            for (genvar j = 0; j < N; j++) begin : g_add
                logic [W-2:0] a_w;
                logic [W-2:0] b_w;
                assign a_w = g_lvl[k-1].data[(2*j)*(W-1) +: (W-1)];
                assign b_w = g_lvl[k-1].data[(2*j+1)*(W-1) +: (W-1)];
                assign sum_d[j*W +: W] = {a_w[W-2], a_w} + {b_w[W-2], b_w};
            end

            always_ff @(posedge clk_in) begin
                if (rst_in) begin
                    vld_q <= 1'b0;
                    lst_q <= 1'b0;
                end else if (adv) begin
                    data_q <= sum_d;
                    vld_q  <= g_lvl[k-1].vld;
                    lst_q  <= g_lvl[k-1].lst;
                end
            end

            assign data = data_q;
            assign vld  = vld_q;
            assign lst  = lst_q;
        end
    end

    logic signed [TW-1:0]        tree_sum;
    logic signed [OUT_WIDTH-1:0] acc_base;
    logic signed [OUT_WIDTH-1:0] acc_next;

    assign tree_sum = g_lvl[L].data;
    assign acc_base = first_q ? '0 : acc_q;

`ifdef ADDER_TREE_SATURATE_EN
    logic signed [OUT_WIDTH:0] acc_wide;
    assign acc_wide = (OUT_WIDTH+1)'(acc_base) + (OUT_WIDTH+1)'(tree_sum);

    // The top two bits disagree only when the sum left the representable range.
    always_comb begin
        acc_next = acc_wide[OUT_WIDTH-1:0];
        if (acc_wide[OUT_WIDTH] != acc_wide[OUT_WIDTH-1]) begin
            acc_next = acc_wide[OUT_WIDTH] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                           : {1'b0, {(OUT_WIDTH-1){1'b1}}};
        end
    end
`else
    assign acc_next = acc_base + OUT_WIDTH'(tree_sum);
`endif

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            acc_q       <= '0;
            first_q     <= 1'b1;
        end else if (adv) begin
            out_valid_q <= 1'b0;
            if (g_lvl[L].vld) begin
                if (g_lvl[L].lst) begin
                    out_data_q  <= acc_next;
                    out_valid_q <= 1'b1;
                    first_q     <= 1'b1;
                end else begin
                    acc_q   <= acc_next;
                    first_q <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_pipelined_adder_tree.sv
// Directed bench for pipelined_adder_tree across three configurations (4x8->32, 16x8->32, 16x8->12).
module tb_pipelined_adder_tree;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [31:0]  a_data;
    logic         a_valid, a_last, a_ready, a_ovalid, a_oready;
    logic [31:0]  a_out;
    logic [127:0] b_data;
    logic         b_valid, b_last, b_ready, b_ovalid, b_oready;
    logic [31:0]  b_out;
    logic [127:0] c_data;
    logic         c_valid, c_last, c_ready, c_ovalid, c_oready;
    logic [11:0]  c_out;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] got_b[$];
    logic [11:0] got_c[$];

    pipelined_adder_tree #(.ELEMENTS(4), .IN_WIDTH(8), .OUT_WIDTH(32)) dut_a (
        .clk_in(clk), .rst_in(rst), .in_data(a_data), .in_valid(a_valid), .in_last(a_last),
        .in_ready(a_ready), .out_data(a_out), .out_valid(a_ovalid), .out_ready(a_oready));
    pipelined_adder_tree #(.ELEMENTS(16), .IN_WIDTH(8), .OUT_WIDTH(32)) dut_b (
        .clk_in(clk), .rst_in(rst), .in_data(b_data), .in_valid(b_valid), .in_last(b_last),
        .in_ready(b_ready), .out_data(b_out), .out_valid(b_ovalid), .out_ready(b_oready));
    pipelined_adder_tree #(.ELEMENTS(16), .IN_WIDTH(8), .OUT_WIDTH(12)) dut_c (
        .clk_in(clk), .rst_in(rst), .in_data(c_data), .in_valid(c_valid), .in_last(c_last),
        .in_ready(c_ready), .out_data(c_out), .out_valid(c_ovalid), .out_ready(c_oready));

    // Record every completed output handshake, sampled well clear of the rising edge.
    always begin
        @(negedge clk);
        #2;
        if (b_ovalid && b_oready) got_b.push_back(b_out);
        if (c_ovalid && c_oready) got_c.push_back(c_out);
    end

    task automatic send_b(input logic [127:0] d, input logic last);
        logic seen;
        seen = 1'b0;
        b_data = d; b_valid = 1'b1; b_last = last;
        for (int t = 0; t < 50 && !seen; t++) begin
            #1;
            seen = b_ready;
            @(negedge clk);
        end
        b_valid = 1'b0; b_last = 1'b0;
        n_checks++;
        if (!seen) begin n_fail++; $display("FAIL send_b_accept: beat not accepted within 50 cycles"); end
    endtask

    task automatic send_c(input logic [127:0] d, input logic last);
        logic seen;
        seen = 1'b0;
        c_data = d; c_valid = 1'b1; c_last = last;
        for (int t = 0; t < 50 && !seen; t++) begin
            #1;
            seen = c_ready;
            @(negedge clk);
        end
        c_valid = 1'b0; c_last = 1'b0;
        n_checks++;
        if (!seen) begin n_fail++; $display("FAIL send_c_accept: beat not accepted within 50 cycles"); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a_valid = 1'b0; a_last = 1'b0; a_data = '0; a_oready = 1'b1;
        b_valid = 1'b0; b_last = 1'b0; b_data = '0; b_oready = 1'b1;
        c_valid = 1'b0; c_last = 1'b0; c_data = '0; c_oready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_checks++; if (a_ready !== 1'b0)  begin n_fail++; $display("FAIL reset_a_ready: got %b want 0", a_ready); end
        n_checks++; if (b_ready !== 1'b0)  begin n_fail++; $display("FAIL reset_b_ready: got %b want 0", b_ready); end
        n_checks++; if (c_ready !== 1'b0)  begin n_fail++; $display("FAIL reset_c_ready: got %b want 0", c_ready); end
        n_checks++; if (a_ovalid !== 1'b0) begin n_fail++; $display("FAIL reset_a_ovalid: got %b want 0", a_ovalid); end
        n_checks++; if (b_ovalid !== 1'b0) begin n_fail++; $display("FAIL reset_b_ovalid: got %b want 0", b_ovalid); end
        n_checks++; if (a_out !== 32'd0)   begin n_fail++; $display("FAIL reset_a_out: got %0h want 0", a_out); end
        n_checks++; if (b_out !== 32'd0)   begin n_fail++; $display("FAIL reset_b_out: got %0h want 0", b_out); end
        n_checks++; if (c_out !== 12'd0)   begin n_fail++; $display("FAIL reset_c_out: got %0h want 0", c_out); end
        rst = 1'b0;
        @(negedge clk);
        #1;
        n_checks++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_a_ready: got %b want 1", a_ready); end
        n_checks++; if (b_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_b_ready: got %b want 1", b_ready); end
    endtask

    task automatic test_single_beat();
        logic exp_v;
        @(negedge clk);
        a_data = {8'd4, 8'd3, 8'd2, 8'd1}; a_valid = 1'b1; a_last = 1'b1;
        #1;
        n_checks++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready: got %b want 1", a_ready); end
        @(posedge clk);
        for (int cyc = 1; cyc <= 5; cyc++) begin
            @(negedge clk);
            a_valid = 1'b0; a_last = 1'b0;
            #1;
            exp_v = (cyc == 3);
            n_checks++;
            if (a_ovalid !== exp_v) begin
                n_fail++; $display("FAIL single_ovalid_c%0d: got %b want %b", cyc, a_ovalid, exp_v);
            end
            if (cyc == 3) begin
                n_checks++;
                if (a_out !== 32'd10) begin n_fail++; $display("FAIL single_data: got %0d want 10", a_out); end
            end
        end
    endtask

    task automatic test_signed_extremes();
        logic [7:0] w;
        logic exp_v;
        @(negedge clk);
        w = 8'h80; b_data = {16{w}}; b_valid = 1'b1; b_last = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin w = 8'h7F; b_data = {16{w}}; end
            if (cyc == 2) begin b_valid = 1'b0; b_last = 1'b0; end
            #1;
            exp_v = (cyc == 5) || (cyc == 6);
            n_checks++;
            if (b_ovalid !== exp_v) begin
                n_fail++; $display("FAIL extreme_ovalid_c%0d: got %b want %b", cyc, b_ovalid, exp_v);
            end
            if (cyc == 5) begin
                n_checks++;
                if (b_out !== 32'hFFFF_F800) begin n_fail++; $display("FAIL extreme_min: got %0h want fffff800", b_out); end
            end
            if (cyc == 6) begin
                n_checks++;
                if (b_out !== 32'd2032) begin n_fail++; $display("FAIL extreme_max: got %0d want 2032", b_out); end
            end
        end
    endtask

    task automatic test_multi_beat();
        logic [7:0] w;
        logic exp_v;
        @(negedge clk);
        w = 8'h01; b_data = {16{w}}; b_valid = 1'b1; b_last = 1'b0;
        @(posedge clk);
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(negedge clk);
            if (cyc == 2) b_last = 1'b1;
            if (cyc == 3) begin b_valid = 1'b0; b_last = 1'b0; end
            #1;
            exp_v = (cyc == 7);
            n_checks++;
            if (b_ovalid !== exp_v) begin
                n_fail++; $display("FAIL multi_ovalid_c%0d: got %b want %b", cyc, b_ovalid, exp_v);
            end
            if (cyc == 7) begin
                n_checks++;
                if (b_out !== 32'd48) begin n_fail++; $display("FAIL multi_data: got %0d want 48", b_out); end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] w;
        logic [31:0] exp_q[$];
        @(negedge clk);
        got_b.delete();
        b_oready = 1'b0;
        for (int i = 1; i <= 6; i++) exp_q.push_back(32'(16 * i));
        for (int i = 1; i <= 5; i++) begin
            w = 8'(i);
            send_b({16{w}}, 1'b1);
        end
        w = 8'd6; b_data = {16{w}}; b_valid = 1'b1; b_last = 1'b1;
        for (int cyc = 0; cyc < 4; cyc++) begin
            #1;
            n_checks++; if (b_ready !== 1'b0)  begin n_fail++; $display("FAIL bp_ready_c%0d: got %b want 0", cyc, b_ready); end
            n_checks++; if (b_ovalid !== 1'b1) begin n_fail++; $display("FAIL bp_ovalid_c%0d: got %b want 1", cyc, b_ovalid); end
            n_checks++; if (b_out !== 32'd16)  begin n_fail++; $display("FAIL bp_hold_c%0d: got %0d want 16", cyc, b_out); end
            @(negedge clk);
        end
        b_oready = 1'b1;
        send_b({16{w}}, 1'b1);
        repeat (12) @(negedge clk);
        n_checks++;
        if (got_b.size() != exp_q.size()) begin
            n_fail++; $display("FAIL bp_count: got %0d results want %0d", got_b.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_b.size(); i++) begin
            n_checks++;
            if (got_b[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL bp_order_%0d: got %0d want %0d", i, got_b[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid_group();
        logic [7:0] w;
        @(negedge clk);
        got_b.delete();
        w = 8'h01;
        send_b({16{w}}, 1'b0);
        send_b({16{w}}, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        n_checks++; if (b_ready !== 1'b0)  begin n_fail++; $display("FAIL mid_rst_ready: got %b want 0", b_ready); end
        n_checks++; if (b_ovalid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ovalid: got %b want 0", b_ovalid); end
        n_checks++; if (b_out !== 32'd0)   begin n_fail++; $display("FAIL mid_rst_out: got %0d want 0", b_out); end
        @(negedge clk);
        rst = 1'b0;
        w = 8'h02;
        send_b({16{w}}, 1'b1);
        repeat (8) @(negedge clk);
        n_checks++;
        if (got_b.size() != 1) begin
            n_fail++; $display("FAIL mid_rst_count: got %0d results want 1", got_b.size());
        end else begin
            n_checks++;
            if (got_b[0] !== 32'd32) begin n_fail++; $display("FAIL mid_rst_data: got %0d want 32", got_b[0]); end
        end
    endtask

    task automatic test_saturate();
        logic [7:0]  w;
        logic [11:0] exp_v;
`ifdef ADDER_TREE_SATURATE_EN
        exp_v = 12'h7FF;
`else
        exp_v = 12'hFE0;
`endif
        @(negedge clk);
        got_c.delete();
        w = 8'h7F;
        send_c({16{w}}, 1'b0);
        send_c({16{w}}, 1'b1);
        repeat (8) @(negedge clk);
        n_checks++;
        if (got_c.size() != 1) begin
            n_fail++; $display("FAIL sat_count: got %0d results want 1", got_c.size());
        end else begin
            n_checks++;
            if (got_c[0] !== exp_v) begin n_fail++; $display("FAIL sat_data: got %0h want %0h", got_c[0], exp_v); end
        end
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_signed_extremes();
        test_multi_beat();
        test_backpressure();
        test_reset_mid_group();
        test_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
